pc_sequencer: RTL and testbench

Registered program-counter unit and generalised successor to the combinational next-PC calculator. It owns the PC register and computes the next PC from sequential increment, PC-relative branch/jump, and register-indirect jump with a parametrised forwarding mux on Rs. It adds a precise-exception path (EPC save, vector, RTI return), a sticky halt state and a redirect pulse for pipeline flush. It sits at the head of the fetch stage and drives the instruction-memory address.

---
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-stage control bundle between the decode/hazard logic (master) and the
// program-counter sequencer (slave).
interface pc_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int NFWD  = 3
);
    localparam int FSEL_W = (NFWD > 1) ? $clog2(NFWD) : 1;

    logic                  stall;
    logic                  pc_sel;
    logic                  reg_jmp;
    logic                  halt;
    logic                  siic;
    logic                  rti;
    logic [FSEL_W-1:0]     fwd_sel;
    logic [NFWD*WIDTH-1:0] rs_bus;
    logic [WIDTH-1:0]      imm;

    logic [WIDTH-1:0]      pc;
    logic [WIDTH-1:0]      pc_inc;
    logic [WIDTH-1:0]      epc;
    logic                  exc_active;
    logic                  halted;
    logic                  redirect;

    modport master (
        output stall, pc_sel, reg_jmp, halt, siic, rti, fwd_sel, rs_bus, imm,
        input  pc, pc_inc, epc, exc_active, halted, redirect
    );

    modport slave (
        input  stall, pc_sel, reg_jmp, halt, siic, rti, fwd_sel, rs_bus, imm,
        output pc, pc_inc, epc, exc_active, halted, redirect
    );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with branch/jump targets, forwarded register-indirect
// jumps, precise exception entry/return, sticky halt and a one-cycle flush pulse.
module pc_sequencer #(
    parameter int WIDTH      = 16,
    parameter int INC        = 2,
    parameter int RESET_PC   = 0,
    parameter int EXC_VECTOR = 2,
    parameter int NFWD       = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_sequencer_if.slave   bus
);
    localparam int FSEL_W = (NFWD > 1) ? $clog2(NFWD) : 1;

    localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] VEC_W   = WIDTH'(EXC_VECTOR);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_EXC  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // One decoded action per cycle; every register's next value derives from it.
    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_EXC  = 3'd1,
        ACT_RTI  = 3'd2,
        ACT_HALT = 3'd3,
        ACT_JUMP = 3'd4,
        ACT_SEQ  = 3'd5
    } action_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             redirect_q, redirect_d;

    action_t          action;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] jr_tgt;
    logic [WIDTH-1:0] rs_sel;
    logic [WIDTH-1:0] rs_arr [NFWD];
    logic             exc_active;
    logic             halted;

    // ------------------------------------------------------------------
    // Rs forwarding mux
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NFWD; gi++) begin : g_rs_unpack
            assign rs_arr[gi] = bus.rs_bus[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Out-of-range selects fall back to the register-file copy in slot 0.
    always_comb begin
        rs_sel = rs_arr[0];
        for (int i = 1; i < NFWD; i++) begin
            if (bus.fwd_sel == FSEL_W'(i)) begin
                rs_sel = rs_arr[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Target arithmetic (modulo 2^WIDTH)
    // ------------------------------------------------------------------
    always_comb begin
        pc_inc = pc_q + INC_W;
        br_tgt = pc_inc + bus.imm;
        jr_tgt = rs_sel + bus.imm;
    end

    // ------------------------------------------------------------------
    // Priority decode of the control inputs
    // ------------------------------------------------------------------
    always_comb begin
        action = ACT_SEQ;
        if (bus.stall) begin
            action = ACT_HOLD;
        end else if (state_q == ST_HALT) begin
            action = ACT_HOLD;
        end else if (bus.siic) begin
            action = ACT_EXC;
        end else if (bus.rti) begin
            // Outside the handler a return is meaningless and just advances.
            action = (state_q == ST_EXC) ? ACT_RTI : ACT_SEQ;
        end else if (bus.halt) begin
            action = ACT_HALT;
        end else if (bus.pc_sel) begin
            action = ACT_JUMP;
        end else begin
            action = ACT_SEQ;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register (with the datapath registers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_W;
            epc_q      <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            redirect_q <= redirect_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (action)
            ACT_EXC:  state_d = ST_EXC;
            ACT_RTI:  state_d = ST_RUN;
            ACT_HALT: state_d = ST_HALT;
            default:  state_d = state_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        redirect_d = 1'b0;
        unique case (action)
            ACT_HOLD: begin
                pc_d = pc_q;
            end
            ACT_EXC: begin
                pc_d       = VEC_W;
                redirect_d = 1'b1;
                // A nested exception keeps the original return address.
                if (state_q == ST_RUN) begin
                    epc_d = pc_inc;
                end
            end
            ACT_RTI: begin
                pc_d       = epc_q;
                redirect_d = 1'b1;
            end
            ACT_HALT: begin
                pc_d = pc_q;
            end
            ACT_JUMP: begin
                pc_d       = bus.reg_jmp ? jr_tgt : br_tgt;
                redirect_d = 1'b1;
            end
            default: begin
                pc_d = pc_inc;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        exc_active = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            ST_EXC:  exc_active = 1'b1;
            ST_HALT: halted     = 1'b1;
            default: begin
                exc_active = 1'b0;
                halted     = 1'b0;
            end
        endcase
    end

    assign bus.pc         = pc_q;
    assign bus.pc_inc     = pc_inc;
    assign bus.epc        = epc_q;
    assign bus.exc_active = exc_active;
    assign bus.halted     = halted;
    assign bus.redirect   = redirect_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random stimulus,
// expectations from an architectural model, compared by an independent monitor.
module tb_pc_sequencer;
    localparam int WIDTH = 16;
    localparam int NFWD  = 3;

    typedef struct {
        bit        stall;
        bit        pc_sel;
        bit        reg_jmp;
        bit        halt;
        bit        siic;
        bit        rti;
        bit [1:0]  fwd;
        bit [47:0] rs;
        bit [15:0] imm;
    } stim_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] epc;
        logic        exc;
        logic        hlt;
        logic        redirect;
    } exp_t;

    logic clk;
    logic rst_n;

    pc_sequencer_if #(.WIDTH(WIDTH), .NFWD(NFWD)) bus ();

    pc_sequencer #(
        .WIDTH(WIDTH), .INC(2), .RESET_PC(0), .EXC_VECTOR(2), .NFWD(NFWD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    // Architectural model state
    int m_pc, m_epc;
    bit m_in_exc, m_halted;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snapshot(input bit red);
        exp_t e;
        e.pc       = 16'(m_pc);
        e.epc      = 16'(m_epc);
        e.exc      = m_in_exc;
        e.hlt      = m_halted;
        e.redirect = red;
        return e;
    endfunction

    // Architectural rules, evaluated at the level of "what the instruction means".
    task automatic model_step(input stim_t s);
        int nxt = (m_pc + 2) % 65536;
        int rs_val;
        bit red = 0;
        if (s.stall || m_halted) begin
            // nothing moves
        end else if (s.siic) begin
            if (!m_in_exc) begin
                m_epc    = nxt;
                m_in_exc = 1;
            end
            m_pc = 2;
            red  = 1;
        end else if (s.rti) begin
            if (m_in_exc) begin
                m_pc     = m_epc;
                m_in_exc = 0;
                red      = 1;
            end else begin
                m_pc = nxt;
            end
        end else if (s.halt) begin
            m_halted = 1;
            m_in_exc = 0;
        end else if (s.pc_sel) begin
            rs_val = (s.fwd < 3) ? int'(s.rs[s.fwd*16 +: 16]) : int'(s.rs[15:0]);
            m_pc   = s.reg_jmp ? (rs_val + int'(s.imm)) % 65536
                               : (nxt + int'(s.imm)) % 65536;
            red    = 1;
        end else begin
            m_pc = nxt;
        end
        exp_q.push_back(snapshot(red));
    endtask

    task automatic step(input stim_t s);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.stall   = s.stall;
        bus.pc_sel  = s.pc_sel;
        bus.reg_jmp = s.reg_jmp;
        bus.halt    = s.halt;
        bus.siic    = s.siic;
        bus.rti     = s.rti;
        bus.fwd_sel = s.fwd;
        bus.rs_bus  = s.rs;
        bus.imm     = s.imm;
        model_step(s);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_pc = 0; m_epc = 0; m_in_exc = 0; m_halted = 0;
        exp_q.push_back(snapshot(0));
        #1;
        check("async_rst_pc", bus.pc, 16'h0000);
        check("async_rst_halted", {15'd0, bus.halted}, 16'd0);
    endtask

    task automatic set_pc(input bit [15:0] target);
        stim_t s = idle();
        s.pc_sel   = 1;
        s.reg_jmp  = 1;
        s.rs[15:0] = target;
        step(s);
    endtask

    // Monitor: the registered outputs settle just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", bus.pc, e.pc);
                check("pc_inc", bus.pc_inc, e.pc + 16'd2);
                check("epc", bus.epc, e.epc);
                check("exc_active", {15'd0, bus.exc_active}, {15'd0, e.exc});
                check("halted", {15'd0, bus.halted}, {15'd0, e.hlt});
                check("redirect", {15'd0, bus.redirect}, {15'd0, e.redirect});
            end
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        bus.stall = 0; bus.pc_sel = 0; bus.reg_jmp = 0; bus.halt = 0;
        bus.siic = 0; bus.rti = 0; bus.fwd_sel = '0; bus.rs_bus = '0; bus.imm = '0;

        // Reset and free run
        do_reset();
        repeat (3) step(idle());

        // PC-relative branch backwards
        set_pc(16'h0010);
        s = idle(); s.pc_sel = 1; s.imm = 16'hFFF0; step(s);
        step(idle());

        // Register-indirect jump through forwarding path 2
        set_pc(16'h0040);
        s = idle(); s.pc_sel = 1; s.reg_jmp = 1; s.fwd = 2;
        s.rs = {16'h1000, 16'h3000, 16'h2000}; s.imm = 16'h0004; step(s);
        s.fwd = 3; step(s);

        // Exception entry, nested exception, return
        set_pc(16'h0030);
        s = idle(); s.siic = 1; step(s);
        step(s);
        s = idle(); s.rti = 1; step(s);
        step(s);

        // Sticky halt, then asynchronous reset out of it
        set_pc(16'h0008);
        s = idle(); s.halt = 1; step(s);
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.pc_sel = 1; s.siic = i[0]; s.rti = i[1]; s.imm = 16'h0100;
            step(s);
        end
        do_reset();
        step(idle());

        // Stall masks an exception request, which is taken once released
        set_pc(16'h0020);
        s = idle(); s.stall = 1; s.siic = 1; step(s);
        s.stall = 0; step(s);
        s = idle(); s.rti = 1; step(s);

        // Wrap at the top of the address space
        set_pc(16'hFFFE);
        step(idle());
        step(idle());

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ((i % 97) == 96 || (m_halted && $urandom_range(0, 7) == 0)) begin
                do_reset();
            end
            s         = idle();
            s.stall   = ($urandom_range(0, 4) == 0);
            s.pc_sel  = ($urandom_range(0, 2) == 0);
            s.reg_jmp = $urandom_range(0, 1) == 1;
            s.halt    = ($urandom_range(0, 63) == 0);
            s.siic    = ($urandom_range(0, 15) == 0);
            s.rti     = ($urandom_range(0, 7) == 0);
            s.fwd     = 2'($urandom_range(0, 3));
            s.rs      = {16'($urandom), 16'($urandom), 16'($urandom)};
            s.imm     = 16'($urandom);
            step(s);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
